multicycle_sequencer: RTL

Multi-cycle control sequencer for the ARM-subset CPU datapath. It steps each instruction through FETCH, DECODE, EXECUTE, optional MEMORY and WRITEBACK. It issues the per-phase enable strobes (IR load, ALU latch, flag update, data memory request, register-file write, PC write) using qualifiers from the instruction decoder, and handles handshakes with instruction and data memory. It sits between the instruction decoder, the datapath registers and both memories.

---
 rtl/multicycle_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH, DECODE, EXEC,
// optional MEM and WB, issuing per-phase datapath strobes and memory handshakes.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic             ir_write,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             dec_flag_update,
    input  logic             dec_branch,
    input  logic             dec_invalid,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_latch,
    output logic             flag_write,
    output logic             rf_write,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic              fault_reg;
    logic [1:0]        fault_code_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            wait_reg       <= '0;
            retired_reg    <= '0;
            fault_reg      <= 1'b0;
            fault_code_reg <= 2'b00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (run) state_reg <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_invalid) begin
                        state_reg      <= S_FAULT;
                        fault_reg      <= 1'b1;
                        fault_code_reg <= 2'b01;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (dec_mem_read || dec_mem_write) begin
                        state_reg <= S_MEM;
                        wait_reg  <= '0;
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_MEM: begin
                    // An ack arriving on the final allowed cycle still completes the access.
                    if (dmem_ack) begin
                        state_reg <= S_WB;
                    end else if (wait_reg == WAIT_LAST) begin
                        state_reg      <= S_FAULT;
                        fault_reg      <= 1'b1;
                        fault_code_reg <= 2'b10;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                S_WB: begin
                    retired_reg <= retired_reg + 1'b1;
                    state_reg   <= run ? S_FETCH : S_IDLE;
                end
                S_FAULT: begin
                    state_reg <= S_FAULT;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        alu_latch     = 1'b0;
        flag_write    = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        rf_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel_branch = 1'b0;
        case (state_reg)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_EXEC: begin
                alu_latch  = 1'b1;
                flag_write = dec_flag_update;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
            end
            S_WB: begin
                // A read+write decode is a store, so it never writes the register file.
                pc_write      = 1'b1;
                pc_sel_branch = dec_branch;
                rf_write      = dec_reg_write & ~dec_mem_write;
            end
            default: ;
        endcase
    end

    assign state      = state_reg;
    assign retired    = retired_reg;
    assign fault      = fault_reg;
    assign fault_code = fault_code_reg;

endmodule
